// File: rtl/float_pkg.sv
// Shared float constants and the arbiter FSM encoding; no logic, no latency.
// Backpressure: not applicable.
package float_pkg;

    localparam int FP_WIDTH = 32;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;

    localparam logic [FP_WIDTH-1:0] FP_ZERO = 32'h0000_0000;
    localparam logic [FP_WIDTH-1:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [FP_WIDTH-1:0] FP_HALF = 32'h3F00_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_RESP
    } arb_state_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/float_unit_arbiter_if.sv
// Requester-side and float_add-side signals of the shared-adder arbiter.
// Latency and backpressure are defined by the arbiter using the master modport.
interface float_unit_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int WIDTH = 32
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] op_a;
    logic [N_REQ*WIDTH-1:0] op_b;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ack;
    logic [WIDTH-1:0]       rsp_data;
    logic                   unit_start;
    logic                   unit_ack;
    logic [WIDTH-1:0]       unit_in_1;
    logic [WIDTH-1:0]       unit_in_2;
    logic [WIDTH-1:0]       unit_res;

    modport master (
        input  req, op_a, op_b, rsp_ack, unit_res,
        output gnt, rsp_valid, rsp_data, unit_start, unit_ack, unit_in_1, unit_in_2
    );

    modport slave (
        output req, op_a, op_b, rsp_ack, unit_res,
        input  gnt, rsp_valid, rsp_data, unit_start, unit_ack, unit_in_1, unit_in_2
    );
endinterface

// File: rtl/float_unit_arbiter_rr_arbiter_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Zero latency; no backpressure (pure function of req and ptr).
module rr_arbiter_pick
    import float_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any
);

    int j;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        j        = 0;
        for (int i = 0; i < N_REQ; i++) begin
            // ptr is always below N_REQ, so one subtraction performs the wrap.
            j = int'(ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!any && req[j]) begin
                pick[j]  = 1'b1;
                pick_idx = IDX_W'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/float_unit_arbiter.sv
// Shares one fixed-latency float_add among N_REQ requesters, round-robin, one op at a time.
// gnt one cycle after req is seen in IDLE; rsp_valid holds until the owner's rsp_ack.
module float_unit_arbiter
    import float_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int WIDTH        = 32,
    parameter int UNIT_LATENCY = 8,
    parameter int CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    float_unit_arbiter_if.master bus
);

    localparam int IDX_W = idx_w(N_REQ);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [CNT_W-1:0] cnt;

    logic [N_REQ-1:0] pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             owner_ack;
    logic [N_REQ-1:0] owner_oh;
    logic [IDX_W-1:0] owner_next;

    rr_arbiter_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (bus.req),
        .ptr      (ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    assign owner_ack  = bus.rsp_ack[owner];
    assign owner_oh   = N_REQ'(1) << owner;
    assign owner_next = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (pick_any)  state_nxt = S_START;
            S_START:                  state_nxt = S_WAIT;
            S_WAIT:    if (cnt == '0) state_nxt = S_CAPTURE;
            S_CAPTURE:                state_nxt = S_RESP;
            S_RESP:    if (owner_ack) state_nxt = S_IDLE;
            default:                  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each lines up with its state cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.gnt        <= '0;
            bus.rsp_valid  <= '0;
            bus.unit_start <= 1'b0;
            bus.unit_ack   <= 1'b0;
            bus.rsp_data   <= '0;
            bus.unit_in_1  <= '0;
            bus.unit_in_2  <= '0;
            cnt            <= '0;
            ptr            <= '0;
            owner          <= '0;
        end else begin
            bus.gnt        <= (state == S_IDLE && pick_any) ? pick : '0;
            bus.unit_start <= (state == S_IDLE) && pick_any;
            bus.unit_ack   <= (state_nxt == S_CAPTURE);
            bus.rsp_valid  <= (state_nxt == S_RESP) ? owner_oh : '0;
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        bus.unit_in_1 <= bus.op_a[pick_idx*WIDTH +: WIDTH];
                        bus.unit_in_2 <= bus.op_b[pick_idx*WIDTH +: WIDTH];
                        owner         <= pick_idx;
                    end
                end
                S_START:   cnt <= CNT_W'(UNIT_LATENCY - 1);
                S_WAIT:    if (cnt != '0) cnt <= cnt - 1'b1;
                S_CAPTURE: bus.rsp_data <= bus.unit_res;
                S_RESP:    if (owner_ack) ptr <= owner_next;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/float_unit_arbiter.md
Name: float_unit_arbiter

Overview:
- Scheduler that shares one float_add datapath (start/ack handshake, operands fl_in_1/fl_in_2, result res) between N_REQ requesters.
- Grants the unit to one requester at a time in round-robin order and latches that requester's operands.
- Drives the unit's start/ack handshake and waits a fixed compute latency.
- Captures the result and returns it to the owner with a valid/ack handshake.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- WIDTH, 32, operand/result width (IEEE-754 single).
- UNIT_LATENCY, 8, cycles from unit_start sampled high to unit_res valid (>=1).
- CNT_W, 4, latency counter width; must hold UNIT_LATENCY-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  level request per requester; must remain high until gnt.
- op_a  in  N_REQ*WIDTH  first operand; slice i belongs to requester i.
- op_b  in  N_REQ*WIDTH  second operand; slice i belongs to requester i.
- gnt  out  N_REQ  one-hot, one-cycle pulse; operands of that requester latched.
- rsp_valid  out  N_REQ  one-hot; owner's result is on rsp_data.
- rsp_ack  in  N_REQ  owner acknowledges the result.
- rsp_data  out  WIDTH  captured result, shared by all requesters.
- unit_start  out  1  start to float_add.
- unit_ack  out  1  ack to float_add.
- unit_in_1  out  WIDTH  operand 1 to float_add.
- unit_in_2  out  WIDTH  operand 2 to float_add.
- unit_res  in  WIDTH  float_add result.

Behaviour:
Reset (rst_n low, asynchronous):
- state=IDLE; gnt, rsp_valid, unit_start, unit_ack = 0.
- rsp_data, unit_in_1, unit_in_2 = 0; counter=0.
- RR pointer set so requester 0 has highest priority.
- Reset mid-operation abandons the operation; nothing is returned.

States (all outputs Moore/registered):
- IDLE: if any req bit is high at the clock edge, select the first set bit at or after ptr, wrapping modulo N_REQ.
  - Latch op_a/op_b slices into unit_in_1/unit_in_2, record owner, go to START.
  - With no req, stay in IDLE.
- START, 1 cycle: gnt[owner]=1 and unit_start=1; counter loaded with UNIT_LATENCY-1; go to WAIT.
- WAIT: decrement counter each cycle; at counter==0 go to CAPTURE. WAIT lasts exactly UNIT_LATENCY cycles.
- CAPTURE, 1 cycle: unit_ack=1; rsp_data<=unit_res at the end of the cycle; go to RESP.
- RESP: rsp_valid[owner]=1, held until rsp_ack[owner] is sampled high.
  - On that edge: rsp_valid drops, ptr<=owner+1 (mod N_REQ), go to IDLE.
  - rsp_ack bits of non-owners are ignored.

Timing and data rules:
- Latency: req accepted at edge k -> gnt/unit_start in cycle k+1; unit_ack in cycle k+2+UNIT_LATENCY; rsp_valid from cycle k+3+UNIT_LATENCY.
- Throughput: one operation per UNIT_LATENCY+4 cycles minimum, counting one IDLE cycle between operations.
- unit_in_1/unit_in_2 are stable from START through CAPTURE; they change only in IDLE.
- rsp_data is stable while rsp_valid is high and holds its value after the ack.
- Simultaneous requests: round-robin. Each requester is served at most once per N_REQ grants while others are requesting.
- req still high after gnt: treated as a new request and arbitrated again.
- rsp_ack asserted in the same cycle rsp_valid first rises: accepted on that edge (valid lasts 1 cycle).
- Requests that arrive while the unit is busy wait; there is no queueing beyond the request level.

Decomposition:
- Shared package float_pkg holds:
  - FP_WIDTH=32, EXP_W=8, MAN_W=23;
  - constants FP_ZERO, FP_ONE=0x3F800000, FP_HALF=0x3F000000;
  - the state encoding (IDLE, START, WAIT, CAPTURE, RESP).
- One sub-module: rr_arbiter_pick, a combinational picker taking req, ptr -> one-hot pick and index.
- The FSM, counter and latches stay in float_unit_arbiter.

Test Plan:
- The bench models float_add as a fixed-latency adder (UNIT_LATENCY=8). Expected response in each scenario follows.
- Reset release, no req:
  - all outputs 0, state stays IDLE for 20 cycles;
  - asserting rst_n low mid-WAIT clears all outputs immediately, and no rsp_valid follows.
- Single op: req[0]=1 with op_a[0]=0x3F000000 (0.5), op_b[0]=0x3F800000 (1.0):
  - gnt[0] pulses one cycle, unit_start one cycle, unit_ack 9 cycles later;
  - rsp_valid[0] with rsp_data=0x3FC00000 (1.5); ack clears it.
- Contention: req=2'b11 held continuously, each ack immediate:
  - grants alternate 0,1,0,1, spaced UNIT_LATENCY+4 cycles apart;
  - requester 1 gets 0x40000000+0x40000000 -> 0x40800000.
- Slow consumer: hold rsp_ack[0] low for 15 cycles:
  - rsp_valid[0] and rsp_data stay stable;
  - no new gnt while req[1]=1 is pending;
  - req[1] is granted on the first IDLE cycle after the ack.
- Wrong ack: rsp_ack[1] pulsed while owner=0 -> ignored, rsp_valid[0] remains high.
- Operand stability: change op_a[0] after gnt -> unit_in_1 is unchanged through CAPTURE, and the result uses the latched value.
